score_display: RTL



---
 rtl/score_display_pkg.sv | 37 +++
 rtl/score_display_seg7_decode.sv | 26 ++
 rtl/score_display.sv | 137 +++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Shared definitions for the score display: FSM states, segment patterns and
// the double-dabble iteration step.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SCORE_MAX = 7'd99;

  // One iteration on {tens, ones, bin}: add 3 to any nibble >= 5, then shift left
  function automatic logic [14:0] dd_step(input logic [14:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[14:11];
    ones = v[10:7];
    if (tens >= 4'd5) tens = tens + 4'd3;
    if (ones >= 4'd5) ones = ones + 4'd3;
    return {tens[2:0], ones, v[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// Combinational BCD nibble to 7-segment decoder; codes above 9 decode as blank.
module seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Two-digit multiplexed 7-segment score display with a sequential
// double-dabble converter that commits both digits atomically.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter bit          BLANK_LZ       = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] cnt_val_i,
  output logic [6:0] seg_o,
  output logic [1:0] dig_sel_o,
  output logic       busy_o
);

  localparam logic [15:0] REF_LAST = 16'(REFRESH_DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_cap;
  logic [6:0]  w_sat;
  logic [14:0] r_shift;
  logic [2:0]  r_it;
  logic [3:0]  r_disp_tens;
  logic [3:0]  r_disp_ones;
  logic [3:0]  w_tens_nxt;
  logic [3:0]  w_ones_nxt;
  logic [3:0]  w_nibble;
  logic [15:0] r_ref;
  logic        r_sel;
  logic        w_sel_nxt;
  logic        w_wrap;
  logic        w_capture;
  logic        w_commit;
  logic [6:0]  w_dec;
  logic [6:0]  w_seg_nxt;
  logic [6:0]  r_seg;
  logic [1:0]  r_dig;

  // Comparing the saturated value keeps an out-of-range input from retriggering forever
  assign w_sat = (cnt_val_i > SCORE_MAX) ? SCORE_MAX : cnt_val_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sat != r_cap) begin
          w_capture   = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_it == 3'd6) w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cap   <= 7'd0;
      r_shift <= 15'd0;
      r_it    <= 3'd0;
    end else if (w_capture) begin
      r_cap   <= w_sat;
      r_shift <= {8'd0, w_sat};
      r_it    <= 3'd0;
    end else if (r_state == SHIFT) begin
      r_shift <= dd_step(r_shift);
      r_it    <= r_it + 3'd1;
    end
  end

  assign w_tens_nxt = w_commit ? r_shift[14:11] : r_disp_tens;
  assign w_ones_nxt = w_commit ? r_shift[10:7]  : r_disp_ones;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_disp_tens <= 4'd0;
      r_disp_ones <= 4'd0;
    end else begin
      r_disp_tens <= w_tens_nxt;
      r_disp_ones <= w_ones_nxt;
    end
  end

  assign w_wrap    = (r_ref == REF_LAST);
  assign w_sel_nxt = r_sel ^ w_wrap;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ref <= 16'd0;
      r_sel <= 1'b0;
    end else begin
      r_ref <= w_wrap ? 16'd0 : r_ref + 16'd1;
      r_sel <= w_sel_nxt;
    end
  end

  // Decode from next-cycle digit and select so a commit or digit switch lands on one edge
  assign w_nibble = w_sel_nxt ? w_tens_nxt : w_ones_nxt;

  seg7_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_dec)
  );

  assign w_seg_nxt = (BLANK_LZ && w_sel_nxt && (w_tens_nxt == 4'd0)) ? SEG_BLANK : w_dec;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_seg <= SEG_0;
      r_dig <= 2'b01;
    end else begin
      r_seg <= w_seg_nxt;
      r_dig <= w_sel_nxt ? 2'b10 : 2'b01;
    end
  end

  assign seg_o     = SEG_ACTIVE_LOW ? ~r_seg : r_seg;
  assign dig_sel_o = SEG_ACTIVE_LOW ? ~r_dig : r_dig;
  assign busy_o    = (r_state != IDLE);

endmodule
